// File: rtl/hilo_div_ctrl_if.sv
// HI/LO divider request/result bundle: decode side drives operands, divider returns writes.
interface hilo_div_ctrl_if;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        done;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_zero;

  modport master (
    output start, is_signed, flush, dividend, divisor,
    input  stall, busy, done, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
  );

  modport slave (
    input  start, is_signed, flush, dividend, divisor,
    output stall, busy, done, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Iterative 32-step restoring DIV/DIVU controller for HI/LO; result 33 cycles after start.
// Optional DIVZERO_DETECT_EN short-circuits divide-by-zero to a one-cycle DONE.
module hilo_div_ctrl (
  input  logic           clk,
  input  logic           resetn,
  hilo_div_ctrl_if.slave div
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
`ifdef DIVZERO_DETECT_EN
  logic        dz_q, dz_d;
`endif

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic        take;
  logic        wr_en;

  always_comb begin
    a_mag   = (div.is_signed && div.dividend[31]) ? -div.dividend : div.dividend;
    b_mag   = (div.is_signed && div.divisor[31])  ? -div.divisor  : div.divisor;
    // remainder:quotient shifted left by one; bit 32 covers remainders above 2^31
    shifted = {rem_q, quo_q[31]};
    take    = (shifted >= {1'b0, dvs_q});

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`ifdef DIVZERO_DETECT_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (div.start && !div.flush) begin
          rem_d   = 32'd0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          sgn_d   = div.is_signed;
          qneg_d  = div.dividend[31] ^ div.divisor[31];
          rneg_d  = div.dividend[31];
          cnt_d   = 6'd0;
          state_d = S_CALC;
`ifdef DIVZERO_DETECT_EN
          dz_d    = 1'b0;
          if (div.divisor == 32'd0) begin
            // raw dividend to HI, all-ones to LO, with the sign fix-up disabled
            rem_d   = div.dividend;
            quo_d   = 32'hFFFF_FFFF;
            sgn_d   = 1'b0;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = take ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_d = {quo_q[30:0], take};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (div.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`ifdef DIVZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`ifdef DIVZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // a flush in DONE cancels the write in the same cycle
  assign wr_en        = (state_q == S_DONE) && !div.flush;
  assign div.done     = wr_en;
  assign div.hi_we    = wr_en;
  assign div.lo_we    = wr_en;
  assign div.busy     = (state_q != S_IDLE);
  assign div.stall    = ((state_q == S_IDLE) && div.start && !div.flush) || (state_q == S_CALC);
  assign div.lo_wdata = (sgn_q && qneg_q) ? -quo_q : quo_q;
  assign div.hi_wdata = (sgn_q && rneg_q) ? -rem_q : rem_q;
`ifdef DIVZERO_DETECT_EN
  assign div.div_zero = wr_en && dz_q;
`else
  assign div.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomized bench for hilo_div_ctrl against a cycle-count/arithmetic reference model.
module tb_hilo_div_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hilo_div_ctrl_if dif ();
  hilo_div_ctrl dut (.clk(clk), .resetn(resetn), .div(dif));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: HI/LO of a MIPS-style divide, computed directly with / and %.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [31:0] ma, mb, q, r;
    dz = 1'b0;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
`ifdef DIVZERO_DETECT_EN
    if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
      return;
    end
`endif
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    lo = (s && (a[31] ^ b[31])) ? (32'd0 - q) : q;
    hi = (s && a[31]) ? (32'd0 - r) : r;
  endfunction

  // Model state: cycles remaining until the result cycle (-1 = no operation pending)
  int          left = -1;
  int          cyc_n = 0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] e_hi = 32'd0, e_lo = 32'd0;
  logic        e_dz = 1'b0;
  logic        exp_done, exp_stall;

  always @(negedge clk) begin
    cyc_n++;
    if (!resetn) begin
      chk1("rst_stall", dif.stall, 1'b0);
      chk1("rst_busy", dif.busy, 1'b0);
      chk1("rst_done", dif.done, 1'b0);
      chk1("rst_hi_we", dif.hi_we, 1'b0);
      chk1("rst_lo_we", dif.lo_we, 1'b0);
      chk1("rst_div_zero", dif.div_zero, 1'b0);
      chk("rst_hi_wdata", dif.hi_wdata, 32'd0);
      chk("rst_lo_wdata", dif.lo_wdata, 32'd0);
      left = -1;
    end else begin
      exp_done  = (left == 0) && !dif.flush;
      exp_stall = ((left < 0) && dif.start && !dif.flush) || (left > 0);
      chk1("busy", dif.busy, left >= 0);
      chk1("stall", dif.stall, exp_stall);
      chk1("done", dif.done, exp_done);
      chk1("hi_we", dif.hi_we, exp_done);
      chk1("lo_we", dif.lo_we, exp_done);
      chk1("div_zero", dif.div_zero, exp_done && e_dz);
      if (exp_done) begin
        chk("hi_wdata", dif.hi_wdata, e_hi);
        chk("lo_wdata", dif.lo_wdata, e_lo);
        chk("latency", 32'(cyc_n - acc_cyc), 32'(exp_lat));
      end
      if (dif.flush) left = -1;
      else if (left < 0 && dif.start) begin
        ref_div(dif.dividend, dif.divisor, dif.is_signed, e_hi, e_lo, e_dz);
        acc_cyc = cyc_n;
        left    = e_dz ? 0 : 32;
        exp_lat = e_dz ? 1 : 33;
      end else if (left >= 0) left--;
    end
  end

  task automatic drive(input logic st, input logic sg, input logic fl,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    dif.start     = st;
    dif.is_signed = sg;
    dif.flush     = fl;
    dif.dividend  = a;
    dif.divisor   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [31:0] p_hi, p_lo, ra, rb;
  logic        p_dz;

  initial begin
    resetn        = 1'b0;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.flush     = 1'b0;
    dif.dividend  = 32'd0;
    dif.divisor   = 32'd0;

    // Hand-computed values that pin the reference model
    ref_div(32'd100, 32'd7, 1'b0, p_hi, p_lo, p_dz);
    chk("pin_100_7_lo", p_lo, 32'd14);
    chk("pin_100_7_hi", p_hi, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, p_hi, p_lo, p_dz);
    chk("pin_m7_2_lo", p_lo, 32'hFFFF_FFFD);
    chk("pin_m7_2_hi", p_hi, 32'hFFFF_FFFF);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, p_hi, p_lo, p_dz);
    chk("pin_min_m1_lo", p_lo, 32'h8000_0000);
    chk("pin_min_m1_hi", p_hi, 32'd0);
    ref_div(32'hFFFF_FFFF, 32'd1, 1'b0, p_hi, p_lo, p_dz);
    chk("pin_max_1_lo", p_lo, 32'hFFFF_FFFF);
    chk("pin_max_1_hi", p_hi, 32'd0);
    ref_div(32'd5, 32'd0, 1'b0, p_hi, p_lo, p_dz);
    chk("pin_5_0_lo", p_lo, 32'hFFFF_FFFF);
    chk("pin_5_0_hi", p_hi, 32'd5);
`ifdef DIVZERO_DETECT_EN
    chk1("pin_5_0_dz", p_dz, 1'b1);
`else
    chk1("pin_5_0_dz", p_dz, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(2);

    // Directed scenarios
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);            idle(36);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);      idle(36);
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); idle(36);
    // further start pulses while the first divide is in flight
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 33; i++) drive(1'b1, i[0], 1'b0, $urandom, $urandom_range(1, 50));
    idle(3);
    // flush at T+10, new request at T+12
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    idle(9);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 32'd9, 32'd3);              idle(36);
    drive(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);              idle(36);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0);      idle(36);
    // flush landing on the result cycle
    drive(1'b1, 1'b0, 1'b0, 32'd20, 32'd3);
    idle(32);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);              idle(3);
    // flush and start together
    drive(1'b1, 1'b0, 1'b1, 32'd50, 32'd5);             idle(3);
    // asynchronous reset in the middle of a divide
    drive(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    idle(5);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk1("async_rst_busy", dif.busy, 1'b0);
    chk1("async_rst_stall", dif.stall, 1'b0);
    chk("async_rst_lo", dif.lo_wdata, 32'd0);
    chk("async_rst_hi", dif.hi_wdata, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(40);

    // Randomized traffic with corner operands and sporadic flushes
    for (int n = 0; n < 6000; n++) begin
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0, ra, rb);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  divide request (DIV/DIVU issued from decode); is_signed  in  1  1=DIV, 0=DIVU; flush  in  1  pipeline flush/exception cancel.
REQ-003 SHALL have ports: dividend  in  32  rs operand; divisor  in  32  rt operand.
REQ-004 SHALL have ports: stall  out  1  hold-pipeline request; busy  out  1  unit occupied; done  out  1  result-valid pulse.
REQ-005 SHALL have ports: hi_we  out  1; lo_we  out  1; hi_wdata  out  32  remainder; lo_wdata  out  32  quotient; div_zero  out  1  divide-by-zero flag.

Function
REQ-006 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-007 IDLE: start=1 and flush=0 -> latch |dividend|, |divisor| (two's-complement magnitude when is_signed=1, raw otherwise), latch sign of dividend, sign of quotient (dividend[31]^divisor[31]) and is_signed; clear 6-bit iteration counter; go CALC.
REQ-008 CALC: one restoring-division step per cycle (shift remainder:quotient left 1, trial subtract divisor, set quotient bit when non-negative); counter increments; after the 32nd step go DONE.
REQ-009 DONE: for exactly one cycle assert done=1, hi_we=1, lo_we=1; go IDLE.
REQ-010 Sign fix-up in DONE when is_signed latched: lo_wdata = quotient negated if quotient sign=1; hi_wdata = remainder negated if dividend sign=1; unsigned: raw values.
REQ-011 Latency: start accepted in cycle T -> done=1 in cycle T+33.
REQ-012 busy SHALL be 1 in CALC and DONE, 0 in IDLE.
REQ-013 stall SHALL be combinational: (IDLE & start & ~flush) | CALC; 0 in DONE so the pipeline advances with the result.
REQ-014 start while not IDLE SHALL be ignored (no re-latch, no effect on the running operation).
REQ-015 flush in any state SHALL force IDLE on the next edge with no hi_we/lo_we/done; flush in DONE SHALL suppress that cycle's writes combinationally.
REQ-016 flush and start in the same IDLE cycle: flush wins, request dropped.
REQ-017 hi_we, lo_we, done SHALL be 0 outside DONE; hi_wdata/lo_wdata don't-care when writes are 0 but SHALL be deterministic (registered values).
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL yield LO=0x80000000, HI=0 (wrap, no trap).

Reset
REQ-019 resetn=0 SHALL asynchronously force IDLE, counter=0, all datapath registers=0.
REQ-020 During/after reset: stall=0, busy=0, done=0, hi_we=0, lo_we=0, div_zero=0, hi_wdata=0, lo_wdata=0.
REQ-021 Reset mid-CALC SHALL abandon the operation; no write occurs after release.

Configuration
REQ-022 Macro DIVZERO_DETECT_EN: when defined, divisor=0 at start SHALL skip CALC (IDLE->DONE directly, done at T+1), output HI=dividend, LO=0xFFFFFFFF, div_zero=1 during that DONE cycle.
REQ-023 Without DIVZERO_DETECT_EN: divisor=0 SHALL run the full 32 steps with natural restoring result (unsigned: LO=0xFFFFFFFF, HI=dividend) and div_zero tied to 0.

Verification
REQ-024 DIVU 100/7 -> done at T+33, LO=14, HI=2, hi_we=lo_we=1 for one cycle, stall high T..T+32.
REQ-025 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-026 DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0; new start pulses during CALC -> result unchanged, no second done.
REQ-027 Start 100/7, flush at T+10 -> IDLE at T+11, no done/we; new start at T+12 of 9/3 -> LO=3, HI=0 at T+45.
REQ-028 DIVU 5/0 -> with DIVZERO_DETECT_EN: done at T+1, LO=0xFFFFFFFF, HI=5, div_zero=1; without: done at T+33, same LO/HI, div_zero=0.
REQ-029 resetn pulsed low at T+5 of an active divide -> all outputs 0 immediately, no write after release.
